sram_port_arbiter: RTL and testbench
====================================

# sram_port_arbiter

Shares the single read/write port (port 0) of the 16×32 `myconfig_sky_dual` macro between two requesters. Requester A is the UART-side `SRAMController` host path; requester B is the `dpu`. Arbitration is round-robin with an optional ownership lock for B's read-modify-write sequences. The block registers the SRAM control signals, tracks in-flight reads, and returns read data only to the requester that issued the read.

## Interface
- `ADDR_W`, default 4: SRAM word-address width.
- `DATA_W`, default 32: SRAM word width.
- `clk` in 1: single clock, shared with the SRAM `clk0`.
- `reset` in 1: synchronous, active-high reset.
- `a_req` in 1: requester A access request; held until `a_gnt`.
- `a_we` in 1: 1 = write, 0 = read.
- `a_addr` in ADDR_W: word address.
- `a_wdata` in DATA_W: write data.
- `a_gnt` out 1: one-cycle acceptance pulse.
- `a_rvalid` out 1: read data valid for A.
- `a_rdata` out DATA_W: read data for A.
- `b_req`, `b_we`, `b_addr`, `b_wdata`, `b_gnt`, `b_rvalid`, `b_rdata`: same meaning as the A ports, for requester B (DPU).
- `b_lock` in 1: B holds port ownership while high.
- `csb_n` out 1: SRAM chip select, active low.
- `we_n` out 1: SRAM write enable, active low.
- `addr` out ADDR_W: SRAM address.
- `sram_data_in` out DATA_W: SRAM write data.
- `sram_data_out` in DATA_W: SRAM read data.

## Operation
- **Reset values:**
  - `csb_n` = 1, `we_n` = 1.
  - `addr`, `sram_data_in`, `a_rdata`, `b_rdata` = 0.
  - All `gnt` and `rvalid` outputs = 0.
  - RR pointer = A, lock = 0, read pipeline is empty.
- **Eligibility:** a requester is eligible in a cycle when its `req` = 1 and its own `gnt` is not high in that cycle. This prevents a double grant on a held `req`.
- **Arbitration, per cycle:**
  - If the lock is set and B is eligible, pick B. A is never picked while the lock is set.
  - Else if exactly one requester is eligible, pick it.
  - Else if both are eligible, pick the requester the RR pointer names.
  - After a pick, the pointer moves to the requester that was not picked.
- **On a pick:** the following are registered at the next edge:
  - `csb_n` = 0.
  - `we_n` = ~we.
  - `addr` and `sram_data_in` from the picked requester.
  - That requester's `gnt` = 1.
  - A requester tag (A/B, plus an is-read flag).
- **With no pick:** `csb_n` = 1 and `we_n` = 1; `addr` and `sram_data_in` hold their values.
- **Lock:**
  - Sets on the edge that grants B while `b_lock` = 1.
  - Clears on the first edge where `b_lock` = 0.
  - If the lock is set and B is idle, the port stays idle and A waits.
- **Read return:** the tag is delayed one cycle. `x_rvalid` pulses and `x_rdata` takes `sram_data_out` for the tagged requester only. The other requester's `rdata` holds.
- **Writes:** no `rvalid` is generated.

## Timing
- Request seen in cycle N → `gnt` and SRAM command driven in N+1 → SRAM samples at the end of N+1 → `rvalid`/`rdata` in N+2. Read latency is 2 cycles from the pick cycle.
- Throughput:
  - Either requester can get at most one grant every 2 cycles.
  - Under contention, grants alternate A/B back-to-back, so the SRAM is busy every cycle.
- Requester rule: `req`, `we`, `addr` and `wdata` stay stable from `req` rise until the `gnt` cycle inclusive. A `req` still high in the `gnt` cycle is ignored in that cycle and treated as a new request in the next cycle.
- Write followed by a read of the same address in consecutive SRAM cycles returns the new data; the macro resolves this, not the arbiter.
- Reset mid-operation:
  - All outputs return to reset values at that edge.
  - In-flight read tags are discarded; no `rvalid` is issued after reset.
  - The lock is cleared.

## Structure
- Shared package `sram_pkg`:
  - `SRAM_ADDR_W` = 4, `SRAM_DATA_W` = 32.
  - Requester-id enum `REQ_A` / `REQ_B`.
  - Tag struct {valid, is_read, id}.
- Sub-module `rr_pick2`: 2-way round-robin picker with a lock override (combinational pick plus pointer register). Everything else lives inline in `sram_port_arbiter`.
- Top-level integration: `SRAMController` connects to the A ports and `dpu` to the B ports. `addr[3:0]` feeds `addr0`.

## Test plan
- **Single A write then read:**
  - Stimulus: A writes 0xDEADBEEF to address 3, then reads address 3.
  - Required: `a_gnt` one cycle after each `req`; `csb_n` = 0 and `we_n` = 0 in the write grant cycle; `a_rvalid` 2 cycles after the read pick with `a_rdata` = 0xDEADBEEF; `b_rvalid` stays 0.
- **Contention:**
  - Stimulus: A and B both hold read requests (address 1 and address 2) from cycle 0; pointer = A.
  - Required: grants A, B, A, B in consecutive cycles; `csb_n` stays low continuously; each `rvalid` goes to the correct owner with that owner's address data.
- **Lock:**
  - Stimulus: B issues a read with `b_lock` = 1, then a write 0x12345678 to the same address; A is requesting throughout.
  - Required: A gets no grant until the cycle after `b_lock` falls; memory holds 0x12345678 before A's access.
- **Held req:**
  - Stimulus: A keeps `req` high for 4 cycles with B idle.
  - Required: `a_gnt` pulses in cycles 1 and 3 only, never in consecutive cycles.
- **Reset mid-read:**
  - Stimulus: assert `reset` in the cycle after a B read grant.
  - Required: `b_rvalid` never pulses; `csb_n` = 1; all `gnt` = 0; after reset the pointer is A (A wins the first contention).
- **Boundary address:**
  - Stimulus: write/read address 15, then address 0.
  - Required: data is independent at each address and there is no wrap corruption.

Source files
------------

// File: rtl/sram_pkg.sv
// Shared types and sizes for the arbitrated 16x32 SRAM port.
package sram_pkg;

  localparam int SRAM_ADDR_W = 4;
  localparam int SRAM_DATA_W = 32;

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_id_e;

  typedef struct packed {
    logic    valid;
    logic    is_read;
    req_id_e id;
  } tag_t;

endpackage

// File: rtl/sram_port_arbiter_rr_pick2.sv
// Two-way round-robin picker; while locked only B can be picked.
module rr_pick2
  import sram_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic a_elig,
  input  logic b_elig,
  input  logic lock,
  output logic pick_valid,
  output logic pick_b
);

  req_id_e ptr_q;
  req_id_e ptr_d;

  always_comb begin
    pick_valid = 1'b0;
    pick_b     = 1'b0;
    if (lock) begin
      pick_valid = b_elig;
      pick_b     = 1'b1;
    end else if (a_elig && b_elig) begin
      pick_valid = 1'b1;
      pick_b     = (ptr_q == REQ_B);
    end else if (a_elig || b_elig) begin
      pick_valid = 1'b1;
      pick_b     = b_elig;
    end

    // Pointer always names the requester that lost (or did not take part in) the last pick.
    ptr_d = ptr_q;
    if (pick_valid) begin
      ptr_d = pick_b ? REQ_A : REQ_B;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= REQ_A;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares SRAM port 0 between the host path (A) and the DPU (B), routing read data
// back only to the requester that issued the read.
module sram_port_arbiter
  import sram_pkg::*;
#(
  parameter int ADDR_W = SRAM_ADDR_W,
  parameter int DATA_W = SRAM_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_gnt,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,
  input  logic              b_lock,
  output logic              csb_n,
  output logic              we_n,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] sram_data_in,
  input  logic [DATA_W-1:0] sram_data_out
);

  logic              csb_n_q, csb_n_d;
  logic              we_n_q, we_n_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              a_gnt_q, a_gnt_d;
  logic              b_gnt_q, b_gnt_d;
  tag_t              tag_q, tag_d;
  logic              a_rvalid_q, a_rvalid_d;
  logic              b_rvalid_q, b_rvalid_d;
  logic              lock_q, lock_d;
  logic [DATA_W-1:0] a_rdata_q, a_rdata_d;
  logic [DATA_W-1:0] b_rdata_q, b_rdata_d;

  logic a_elig, b_elig;
  logic pick_valid, pick_b;

  // A requester whose gnt is high this cycle has already been served.
  assign a_elig = a_req && !a_gnt_q;
  assign b_elig = b_req && !b_gnt_q;

  rr_pick2 u_pick (
    .clk        (clk),
    .reset      (reset),
    .a_elig     (a_elig),
    .b_elig     (b_elig),
    .lock       (lock_q),
    .pick_valid (pick_valid),
    .pick_b     (pick_b)
  );

  always_comb begin
    csb_n_d = 1'b1;
    we_n_d  = 1'b1;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    a_gnt_d = 1'b0;
    b_gnt_d = 1'b0;
    tag_d   = '0;
    if (pick_valid) begin
      csb_n_d = 1'b0;
      if (pick_b) begin
        we_n_d  = ~b_we;
        addr_d  = b_addr;
        wdata_d = b_wdata;
        b_gnt_d = 1'b1;
        tag_d   = '{valid: 1'b1, is_read: ~b_we, id: REQ_B};
      end else begin
        we_n_d  = ~a_we;
        addr_d  = a_addr;
        wdata_d = a_wdata;
        a_gnt_d = 1'b1;
        tag_d   = '{valid: 1'b1, is_read: ~a_we, id: REQ_A};
      end
    end

    if (!b_lock) begin
      lock_d = 1'b0;
    end else if (pick_valid && pick_b) begin
      lock_d = 1'b1;
    end else begin
      lock_d = lock_q;
    end

    // The SRAM returns data the cycle after it sees the command, hence one extra tag stage.
    a_rvalid_d = tag_q.valid && tag_q.is_read && (tag_q.id == REQ_A);
    b_rvalid_d = tag_q.valid && tag_q.is_read && (tag_q.id == REQ_B);

    a_rdata_d = a_rvalid_q ? sram_data_out : a_rdata_q;
    b_rdata_d = b_rvalid_q ? sram_data_out : b_rdata_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      csb_n_q    <= 1'b1;
      we_n_q     <= 1'b1;
      addr_q     <= '0;
      wdata_q    <= '0;
      a_gnt_q    <= 1'b0;
      b_gnt_q    <= 1'b0;
      tag_q      <= '0;
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
      lock_q     <= 1'b0;
      a_rdata_q  <= '0;
      b_rdata_q  <= '0;
    end else begin
      csb_n_q    <= csb_n_d;
      we_n_q     <= we_n_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      a_gnt_q    <= a_gnt_d;
      b_gnt_q    <= b_gnt_d;
      tag_q      <= tag_d;
      a_rvalid_q <= a_rvalid_d;
      b_rvalid_q <= b_rvalid_d;
      lock_q     <= lock_d;
      a_rdata_q  <= a_rdata_d;
      b_rdata_q  <= b_rdata_d;
    end
  end

  assign csb_n        = csb_n_q;
  assign we_n         = we_n_q;
  assign addr         = addr_q;
  assign sram_data_in = wdata_q;
  assign a_gnt        = a_gnt_q;
  assign b_gnt        = b_gnt_q;

  // Read data is forwarded straight from the macro in the valid cycle and held afterwards;
  // a read return that coincides with reset is suppressed so no rvalid escapes a reset.
  assign a_rvalid = a_rvalid_q && !reset;
  assign b_rvalid = b_rvalid_q && !reset;
  assign a_rdata  = a_rvalid ? sram_data_out : a_rdata_q;
  assign b_rdata  = b_rvalid ? sram_data_out : b_rdata_q;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter with a behavioural 16x32 SRAM and a read-data scoreboard.
module tb_sram_port_arbiter;
  import sram_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        a_req = 1'b0, a_we = 1'b0;
  logic [3:0]  a_addr = '0;
  logic [31:0] a_wdata = '0;
  logic        a_gnt, a_rvalid;
  logic [31:0] a_rdata;
  logic        b_req = 1'b0, b_we = 1'b0, b_lock = 1'b0;
  logic [3:0]  b_addr = '0;
  logic [31:0] b_wdata = '0;
  logic        b_gnt, b_rvalid;
  logic [31:0] b_rdata;
  logic        csb_n, we_n;
  logic [3:0]  addr;
  logic [31:0] sram_data_in;
  logic [31:0] sram_data_out = '0;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  logic [31:0] a_exp_q[$];
  logic [31:0] b_exp_q[$];
  logic [31:0] mem [16];

  sram_port_arbiter #(.ADDR_W(4), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata), .b_lock(b_lock),
    .csb_n(csb_n), .we_n(we_n), .addr(addr),
    .sram_data_in(sram_data_in), .sram_data_out(sram_data_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous single-port SRAM: write or read on the rising edge when selected.
  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 32'hA0A0_0000 + 32'(i);
  end
  always @(posedge clk) begin
    if (!csb_n) begin
      if (!we_n) mem[addr] <= sram_data_in;
      else sram_data_out <= mem[addr];
    end
  end

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Scoreboard monitor: each rvalid pops the next expected word for that requester.
  initial begin
    logic [31:0] a_last, b_last, e;
    a_last = '0;
    b_last = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        a_last = '0;
        b_last = '0;
      end else begin
        if (a_rvalid) begin
          if (a_exp_q.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL a_rvalid_unexpected: got rvalid with data %h, required no rvalid", a_rdata);
          end else begin
            e = a_exp_q.pop_front();
            check("a_rdata", a_rdata, e);
            $display("A read returned %h (expected %h) cycle %0d", a_rdata, e, cyc);
          end
          a_last = a_rdata;
          if (!b_rvalid) check("b_rdata_hold", b_rdata, b_last);
        end
        if (b_rvalid) begin
          if (b_exp_q.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL b_rvalid_unexpected: got rvalid with data %h, required no rvalid", b_rdata);
          end else begin
            e = b_exp_q.pop_front();
            check("b_rdata", b_rdata, e);
            $display("B read returned %h (expected %h) cycle %0d", b_rdata, e, cyc);
          end
          b_last = b_rdata;
          if (!a_rvalid) check("a_rdata_hold", a_rdata, a_last);
        end
      end
    end
  end

  task automatic a_access(input logic we, input logic [3:0] ad, input logic [31:0] wd,
                          input logic [31:0] exp, input int exp_lat, output int gnt_cyc);
    int lat;
    logic got;
    logic exp_we_n;
    exp_we_n = ~we;
    @(posedge clk); #1;
    a_req = 1'b1; a_we = we; a_addr = ad; a_wdata = wd;
    if (!we) a_exp_q.push_back(exp);
    lat = 0; got = 1'b0; gnt_cyc = 0;
    while (!got && lat < 40) begin
      @(negedge clk); lat++;
      if (a_gnt) got = 1'b1;
    end
    if (!got) begin
      n_checks++; n_fail++;
      $display("FAIL a_gnt_timeout: no grant after %0d cycles, required a grant", lat);
      a_req = 1'b0;
      return;
    end
    gnt_cyc = cyc;
    $display("A %s addr %0d granted cycle %0d", we ? "write" : "read", ad, cyc);
    if (exp_lat > 0) check("a_gnt_latency", 32'(lat), 32'(exp_lat));
    check("a_csb_n", 32'(csb_n), 32'd0);
    check("a_we_n", 32'(we_n), 32'(exp_we_n));
    check("a_addr", 32'(addr), 32'(ad));
    if (we) check("a_sram_din", sram_data_in, wd);
    @(posedge clk); #1;
    a_req = 1'b0;
    if (!we) begin
      @(negedge clk);
      check("a_rvalid_latency", 32'(a_rvalid), 32'd1);
    end
  endtask

  task automatic b_access(input logic we, input logic [3:0] ad, input logic [31:0] wd,
                          input logic [31:0] exp, input logic lock, input int exp_lat);
    int lat;
    logic got;
    logic exp_we_n;
    exp_we_n = ~we;
    @(posedge clk); #1;
    b_req = 1'b1; b_we = we; b_addr = ad; b_wdata = wd; b_lock = lock;
    if (!we) b_exp_q.push_back(exp);
    lat = 0; got = 1'b0;
    while (!got && lat < 40) begin
      @(negedge clk); lat++;
      if (b_gnt) got = 1'b1;
    end
    if (!got) begin
      n_checks++; n_fail++;
      $display("FAIL b_gnt_timeout: no grant after %0d cycles, required a grant", lat);
      b_req = 1'b0;
      return;
    end
    $display("B %s addr %0d granted cycle %0d", we ? "write" : "read", ad, cyc);
    if (exp_lat > 0) check("b_gnt_latency", 32'(lat), 32'(exp_lat));
    check("b_csb_n", 32'(csb_n), 32'd0);
    check("b_we_n", 32'(we_n), 32'(exp_we_n));
    check("b_addr", 32'(addr), 32'(ad));
    if (we) check("b_sram_din", sram_data_in, wd);
    @(posedge clk); #1;
    b_req = 1'b0;
    if (!we) begin
      @(negedge clk);
      check("b_rvalid_latency", 32'(b_rvalid), 32'd1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int gc;
    int fall_cyc;
    logic [4:0] ctn_a, ctn_b, ctn_csb;
    logic [5:0] held_a;

    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_csb_n", 32'(csb_n), 32'd1);
    check("rst_we_n", 32'(we_n), 32'd1);
    check("rst_addr", 32'(addr), 32'd0);
    check("rst_din", sram_data_in, 32'd0);
    check("rst_gnt", {30'd0, a_gnt, b_gnt}, 32'd0);
    check("rst_rvalid", {30'd0, a_rvalid, b_rvalid}, 32'd0);
    check("rst_a_rdata", a_rdata, 32'd0);
    check("rst_b_rdata", b_rdata, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Contention: both hold reads for four cycles, pointer starts at A.
    ctn_a = 5'b01010; ctn_b = 5'b10100; ctn_csb = 5'b00001;
    @(posedge clk); #1;
    a_req = 1'b1; a_we = 1'b0; a_addr = 4'd1;
    b_req = 1'b1; b_we = 1'b0; b_addr = 4'd2;
    a_exp_q.push_back(32'hA0A0_0001); a_exp_q.push_back(32'hA0A0_0001);
    b_exp_q.push_back(32'hA0A0_0002); b_exp_q.push_back(32'hA0A0_0002);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) begin @(posedge clk); #1; end
      if (i == 4) begin a_req = 1'b0; b_req = 1'b0; end
      @(negedge clk);
      $display("contention cycle %0d: a_gnt=%0d b_gnt=%0d csb_n=%0d", i, a_gnt, b_gnt, csb_n);
      check("ctn_a_gnt", 32'(a_gnt), 32'(ctn_a[i]));
      check("ctn_b_gnt", 32'(b_gnt), 32'(ctn_b[i]));
      check("ctn_csb_n", 32'(csb_n), 32'(ctn_csb[i]));
    end
    repeat (4) @(negedge clk);

    // Single A write then read
    a_access(1'b1, 4'd3, 32'hDEAD_BEEF, 32'h0, 2, gc);
    a_access(1'b0, 4'd3, 32'h0, 32'hDEAD_BEEF, 2, gc);

    // Held request: A write held four cycles, B idle
    held_a = 6'b001010;
    @(posedge clk); #1;
    a_req = 1'b1; a_we = 1'b1; a_addr = 4'd5; a_wdata = 32'h5555_5555;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) begin @(posedge clk); #1; end
      if (i == 4) a_req = 1'b0;
      @(negedge clk);
      $display("held cycle %0d: a_gnt=%0d", i, a_gnt);
      check("held_a_gnt", 32'(a_gnt), 32'(held_a[i]));
    end

    // Lock: B read-modify-write on address 7 while A keeps asking for address 7
    fall_cyc = 0;
    fork
      begin
        b_access(1'b0, 4'd7, 32'h0, 32'hA0A0_0007, 1'b1, 2);
        b_access(1'b1, 4'd7, 32'h1234_5678, 32'h0, 1'b1, 2);
        b_lock = 1'b0;
        fall_cyc = cyc;
      end
      begin
        @(posedge clk);
        a_access(1'b0, 4'd7, 32'h0, 32'h1234_5678, 0, gc);
      end
    join
    check("lock_a_after_release", 32'(gc > fall_cyc), 32'd1);

    // Boundary addresses
    a_access(1'b1, 4'd15, 32'hF00D_F00D, 32'h0, 2, gc);
    b_access(1'b1, 4'd0, 32'h0BAD_CAFE, 32'h0, 1'b0, 2);
    a_access(1'b0, 4'd15, 32'h0, 32'hF00D_F00D, 2, gc);
    b_access(1'b0, 4'd0, 32'h0, 32'h0BAD_CAFE, 1'b0, 2);
    a_access(1'b0, 4'd14, 32'h0, 32'hA0A0_000E, 2, gc);

    // Reset in the cycle after a B read grant
    @(posedge clk); #1;
    b_req = 1'b1; b_we = 1'b0; b_addr = 4'd9;
    @(posedge clk); #1;
    a_req = 1'b1; a_we = 1'b1; a_addr = 4'd10; a_wdata = 32'h0;
    @(negedge clk);
    check("rr_b_gnt", 32'(b_gnt), 32'd1);
    @(posedge clk); #1;
    b_req = 1'b0; a_req = 1'b0; reset = 1'b1;
    @(negedge clk);
    check("rr_b_rvalid_in_reset", 32'(b_rvalid), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("rr_csb_n", 32'(csb_n), 32'd1);
    check("rr_gnt", {30'd0, a_gnt, b_gnt}, 32'd0);
    check("rr_b_rvalid", 32'(b_rvalid), 32'd0);
    @(negedge clk);
    check("rr_b_rvalid_late", 32'(b_rvalid), 32'd0);
    fork
      a_access(1'b0, 4'd1, 32'h0, 32'hA0A0_0001, 2, gc);
      b_access(1'b0, 4'd2, 32'h0, 32'hA0A0_0002, 1'b0, 3);
    join

    repeat (4) @(negedge clk);
    check("a_scoreboard_empty", 32'(a_exp_q.size()), 32'd0);
    check("b_scoreboard_empty", 32'(b_exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
